// File: rtl/aes_dec_top.sv
// Iterative AES-128 decryptor, one round per clock, with an on-the-fly inverse key schedule.
// Define AES_DEC_REDUNDANCY_EN to run the decrypt twice and flag disagreement on fault_flag.
package aes_dec_pkg;
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254; maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
        x2   = gmul(x, x);
        x3   = gmul(x2, x);
        x6   = gmul(x3, x3);
        x12  = gmul(x6, x6);
        x15  = gmul(x12, x3);
        x30  = gmul(x15, x15);
        x60  = gmul(x30, x30);
        x120 = gmul(x60, x60);
        x240 = gmul(x120, x120);
        x252 = gmul(x240, x12);
        return gmul(x252, x2);
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int unsigned n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction
endpackage

module aes_sbox import aes_dec_pkg::*; (
    input  logic [7:0] a,
    output logic [7:0] y
);
    logic [7:0] b;
    assign b = gf_inv(a);
    assign y = b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
endmodule

module aes_inv_sbox import aes_dec_pkg::*; (
    input  logic [7:0] a,
    output logic [7:0] y
);
    logic [7:0] t;
    assign t = rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05;
    assign y = gf_inv(t);
endmodule

module aes_dec_top import aes_dec_pkg::*; #(
    parameter bit ZERO_ON_FAULT = 1'b1,
    parameter bit DONE_HOLD     = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key,
    input  logic [127:0] ciphertext,
    output logic         busy,
    output logic         done,
    output logic [127:0] plaintext,
    output logic         fault_flag
);
    typedef enum logic [2:0] {IDLE, KEXP, INIT, ROUND, FINAL, CHECK} fsm_t;

    fsm_t         fsm_reg, fsm_next;
    logic [3:0]   round_reg, round_next;
    logic [127:0] state_reg, state_next;
    logic [127:0] key_reg, key_next;
    logic [127:0] pt_reg, pt_next;
    logic         busy_reg, busy_next;
    logic         done_reg, done_next;
`ifdef AES_DEC_REDUNDANCY_EN
    logic         pass_reg, pass_next;
    logic         fault_reg, fault_next;
    logic [127:0] result_reg, result_next;
    logic [127:0] ct_reg, ct_next;
    logic [127:0] key_lat_reg, key_lat_next;
`endif

    logic         accept;
    logic [127:0] isr, isb, ark, imc, fwd_key, inv_key;
    logic [31:0]  w0, w1, w2, w3, sub_in, rot_word, sub_out, rcon_word;

    assign accept = start && !busy_reg;

    for (genvar gi = 0; gi < 16; gi++) begin : g_bytes
        localparam int SRC = ((((gi / 4) - (gi % 4) + 4) % 4) * 4) + (gi % 4);
        assign isr[127-8*gi -: 8] = state_reg[127-8*SRC -: 8];
        aes_inv_sbox u_isb (.a(isr[127-8*gi -: 8]), .y(isb[127-8*gi -: 8]));
    end

    assign ark = isb ^ key_reg;

    for (genvar gi = 0; gi < 4; gi++) begin : g_cols
        logic [7:0] a0, a1, a2, a3;
        assign a0 = ark[127-32*gi -: 8];
        assign a1 = ark[119-32*gi -: 8];
        assign a2 = ark[111-32*gi -: 8];
        assign a3 = ark[103-32*gi -: 8];
        assign imc[127-32*gi -: 32] = {
            gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
            gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
            gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
            gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
    end

    // One SubWord unit serves both directions: w3 going forward, w3^w2 going backward.
    assign {w0, w1, w2, w3} = key_reg;
    assign sub_in    = (fsm_reg == KEXP) ? w3 : (w3 ^ w2);
    assign rot_word  = {sub_in[23:0], sub_in[31:24]};
    assign rcon_word = {rcon(round_reg), 24'h000000};

    for (genvar gi = 0; gi < 4; gi++) begin : g_ksub
        aes_sbox u_sb (.a(rot_word[31-8*gi -: 8]), .y(sub_out[31-8*gi -: 8]));
    end

    always_comb begin
        logic [31:0] n0, n1, n2;
        n0      = w0 ^ sub_out ^ rcon_word;
        n1      = w1 ^ n0;
        n2      = w2 ^ n1;
        fwd_key = {n0, n1, n2, w3 ^ n2};
        inv_key = {w0 ^ sub_out ^ rcon_word, w1 ^ w0, w2 ^ w1, w3 ^ w2};
    end

    always_comb begin
        fsm_next   = fsm_reg;
        round_next = round_reg;
        state_next = state_reg;
        key_next   = key_reg;
        pt_next    = pt_reg;
        busy_next  = busy_reg;
        done_next  = DONE_HOLD ? done_reg : 1'b0;
`ifdef AES_DEC_REDUNDANCY_EN
        pass_next    = pass_reg;
        fault_next   = fault_reg;
        result_next  = result_reg;
        ct_next      = ct_reg;
        key_lat_next = key_lat_reg;
`endif
        case (fsm_reg)
            IDLE, CHECK: begin
                fsm_next = IDLE;
                if (accept) begin
                    fsm_next   = KEXP;
                    round_next = 4'd1;
                    state_next = ciphertext;
                    key_next   = key;
                    pt_next    = '0;
                    busy_next  = 1'b1;
                    done_next  = 1'b0;
`ifdef AES_DEC_REDUNDANCY_EN
                    pass_next    = 1'b0;
                    fault_next   = 1'b0;
                    ct_next      = ciphertext;
                    key_lat_next = key;
`endif
                end
            end
            KEXP: begin
                key_next = fwd_key;
                if (round_reg == 4'd10) fsm_next = INIT;
                else                    round_next = round_reg + 4'd1;
            end
            INIT: begin
                state_next = state_reg ^ key_reg;
                key_next   = inv_key;
                round_next = round_reg - 4'd1;
                fsm_next   = ROUND;
            end
            ROUND: begin
                state_next = imc;
                key_next   = inv_key;
                round_next = round_reg - 4'd1;
                if (round_reg == 4'd1) fsm_next = FINAL;
            end
            FINAL: begin
                state_next = ark;
`ifdef AES_DEC_REDUNDANCY_EN
                if (!pass_reg) begin
                    result_next = ark;
                    pass_next   = 1'b1;
                    state_next  = ct_reg;
                    key_next    = key_lat_reg;
                    round_next  = 4'd1;
                    fsm_next    = KEXP;
                end else begin
                    // The compare result lands in the output registers so CHECK already shows it.
                    fsm_next  = CHECK;
                    busy_next = 1'b0;
                    done_next = 1'b1;
                    if (ark == result_reg) begin
                        pt_next    = ark;
                        fault_next = 1'b0;
                    end else begin
                        pt_next    = ZERO_ON_FAULT ? '0 : result_reg;
                        fault_next = 1'b1;
                    end
                end
`else
                fsm_next  = CHECK;
                busy_next = 1'b0;
                done_next = 1'b1;
                pt_next   = ark;
`endif
            end
            default: fsm_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_reg   <= IDLE;
            round_reg <= '0;
            state_reg <= '0;
            key_reg   <= '0;
            pt_reg    <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
`ifdef AES_DEC_REDUNDANCY_EN
            pass_reg    <= 1'b0;
            fault_reg   <= 1'b0;
            result_reg  <= '0;
            ct_reg      <= '0;
            key_lat_reg <= '0;
`endif
        end else begin
            fsm_reg   <= fsm_next;
            round_reg <= round_next;
            state_reg <= state_next;
            key_reg   <= key_next;
            pt_reg    <= pt_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
`ifdef AES_DEC_REDUNDANCY_EN
            pass_reg    <= pass_next;
            fault_reg   <= fault_next;
            result_reg  <= result_next;
            ct_reg      <= ct_next;
            key_lat_reg <= key_lat_next;
`endif
        end
    end

    assign busy      = busy_reg;
    assign done      = done_reg;
    assign plaintext = pt_reg;
`ifdef AES_DEC_REDUNDANCY_EN
    assign fault_flag = fault_reg;
`else
    assign fault_flag = 1'b0;
`endif
endmodule

// File: tb/tb_aes_dec_top.sv
// Directed bench for aes_dec_top: FIPS-197 / SP800-38A vectors, handshake, fault injection, reset abort.
module tb_aes_dec_top;
    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] key;
    logic [127:0] ciphertext;
    logic         busy;
    logic         done;
    logic [127:0] plaintext;
    logic         fault_flag;

    int checks   = 0;
    int failures = 0;

`ifdef AES_DEC_REDUNDANCY_EN
    localparam int LAT = 43;
`else
    localparam int LAT = 22;
`endif

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;

    logic [127:0] vk [0:4];
    logic [127:0] vc [0:4];
    logic [127:0] vp [0:4];

    aes_dec_top dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .key        (key),
        .ciphertext (ciphertext),
        .busy       (busy),
        .done       (done),
        .plaintext  (plaintext),
        .fault_flag (fault_flag)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s value=%h", tag, got);
        end
    endtask

    // Called 1 time unit after an edge; returns 1 time unit after the accepting edge (cycle 1).
    task automatic do_start(input logic [127:0] k, input logic [127:0] c);
        start      = 1'b1;
        key        = k;
        ciphertext = c;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int c0, output int cyc);
        cyc = c0;
        while (done !== 1'b1 && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic run_vec(input string tag, input logic [127:0] k, input logic [127:0] c,
                           input logic [127:0] p);
        int cyc;
        do_start(k, c);
        wait_done(1, cyc);
        check_eq({tag, "_lat"}, 128'(cyc), 128'(LAT));
        check_eq({tag, "_pt"}, plaintext, p);
        check_eq({tag, "_fault"}, 128'(fault_flag), 128'(0));
    endtask

    initial begin
        int cyc;
        int n;
        logic [127:0] inj;

        vk[0] = K2; vp[0] = 128'h6bc1bee22e409f96e93d7e117393172a; vc[0] = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
        vk[1] = K2; vp[1] = 128'hae2d8a571e03ac9c9eb76fac45af8e51; vc[1] = 128'hf5d3d58503b9699de785895a96fdbaaf;
        vk[2] = K2; vp[2] = 128'h30c81c46a35ce411e5fbc1191a0a52ef; vc[2] = 128'h43b1cd7f598ece23881b00e3ed030688;
        vk[3] = K2; vp[3] = 128'hf69f2445df4f9b17ad2b417be66c3710; vc[3] = 128'h7b0c785e27e8ad3f8223207104725dd4;
        vk[4] = '0; vp[4] = '0;                                   vc[4] = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

        rst = 1'b1; start = 1'b0; key = '0; ciphertext = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("rst_busy", 128'(busy), 128'(0));
        check_eq("rst_done", 128'(done), 128'(0));
        check_eq("rst_pt", plaintext, '0);
        check_eq("rst_fault", 128'(fault_flag), 128'(0));

        // T1 / T2: FIPS-197 vectors, done pulse and plaintext hold
        do_start(K1, C1);
        check_eq("t1_busy", 128'(busy), 128'(1));
        wait_done(1, cyc);
        check_eq("t1_lat", 128'(cyc), 128'(LAT));
        check_eq("t1_pt", plaintext, P1);
        check_eq("t1_fault", 128'(fault_flag), 128'(0));
        check_eq("t1_busy_done", 128'(busy), 128'(0));
        @(posedge clk);
        #1;
        check_eq("t1_done_pulse", 128'(done), 128'(0));
        check_eq("t1_pt_hold", plaintext, P1);
        run_vec("t2", K2, C2, P2);

        // T3: further known-answer vectors
        for (int i = 0; i < 5; i++) run_vec($sformatf("t3_%0d", i), vk[i], vc[i], vp[i]);

        // T4: corrupt state_reg during pass-1 key expansion
        do_start(K1, C1);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        inj = dut.state_reg ^ 128'h1;
        force dut.state_reg = inj;
        @(posedge clk);
        #1;
        release dut.state_reg;
        wait_done(5, cyc);
        check_eq("t4_lat", 128'(cyc), 128'(LAT));
`ifdef AES_DEC_REDUNDANCY_EN
        check_eq("t4_fault", 128'(fault_flag), 128'(1));
        check_eq("t4_pt_zero", plaintext, '0);
`else
        check_eq("t4_fault", 128'(fault_flag), 128'(0));
`endif
        run_vec("t4_clean", K1, C1, P1);

        // T5: start while busy, input changes after accept, restart in done cycle
        do_start(K1, C1);
        cyc = 1;
        while (done !== 1'b1 && cyc < 200) begin
            start      = (cyc == 3 || cyc == 20);
            key        = {$urandom, $urandom, $urandom, $urandom};
            ciphertext = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk);
            #1;
            cyc++;
        end
        start = 1'b0;
        check_eq("t5_lat", 128'(cyc), 128'(LAT));
        check_eq("t5_pt", plaintext, P1);
        do_start(K2, C2);
        wait_done(1, cyc);
        check_eq("t5_b2b_lat", 128'(cyc), 128'(LAT));
        check_eq("t5_b2b_pt", plaintext, P2);
        n = 0;
        repeat (50) begin
            @(posedge clk);
            #1;
            if (done) n++;
        end
        check_eq("t5_no_extra_done", 128'(n), 128'(0));

        // T6: reset mid-operation
        do_start(K1, C1);
        repeat (14) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("t6_busy", 128'(busy), 128'(0));
        check_eq("t6_done", 128'(done), 128'(0));
        check_eq("t6_pt", plaintext, '0);
        check_eq("t6_fault", 128'(fault_flag), 128'(0));
        n = 0;
        repeat (60) begin
            @(posedge clk);
            #1;
            if (done) n++;
        end
        check_eq("t6_no_done", 128'(n), 128'(0));
        run_vec("t6_after", K2, C2, P2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
